flex_viterbi_core: RTL and testbench

FLEX_VITERBI_CORE -- requirements
Module: flex_viterbi_core

---
 rtl/flex_viterbi_pkg.sv | 19 +
 rtl/flex_viterbi_core_delay.sv | 36 +++
 rtl/flex_viterbi_core.sv | 152 +++++++++++++++
 tb/tb_flex_viterbi_core.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flex_viterbi_pkg.sv
// Shared types and constants for the flex Viterbi symbol core.
package flex_viterbi_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SLICE = 2'd1,
        MODE_PRBS  = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    localparam logic [6:0] LFSR_SEED = 7'h7F;
    // x^7 + x^6 + 1: feedback from the two oldest bits
    localparam logic [6:0] LFSR_TAPS = 7'b110_0000;

    function automatic logic [6:0] lfsr_step(input logic [6:0] s);
        return {s[5:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/flex_viterbi_core_delay.sv
// Fixed-latency register delay line with sync clear and a flush that
// zeroes every stage except the last.
module viterbi_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stg
        localparam bit FLUSHABLE = (i < DEPTH - 1);
        logic [WIDTH-1:0] nxt;

        if (i == 0) begin : g_head
            assign nxt = d;
        end else begin : g_body
            assign nxt = stg[i-1];
        end

        always_ff @(posedge clk) begin
            if (clr || (FLUSHABLE && flush))
                stg[i] <= '0;
            else
                stg[i] <= nxt;
        end
    end

    assign q = stg[DEPTH-1];

endmodule

// File: rtl/flex_viterbi_core.sv
// Symbol generator (count / slice / PRBS) with uniform H_DEPTH latency on
// data and frame control, plus frame-position sequence check and frame counter.
module flex_viterbi_core
    import flex_viterbi_pkg::*;
#(
    parameter int num_of_channels = 40,
    parameter int B_WIDTH         = 8,
    parameter int B_LEN           = 2,
    parameter int SYM_WIDTH       = 3,
    parameter int H_DEPTH         = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [B_LEN-1:0][B_WIDTH-1:0]       rse_vals,
    input  logic                                run,
    input  logic                                initialize,
    input  logic                                frame_end,
    input  logic [$clog2(num_of_channels)-1:0]  frame_position,
    input  logic [1:0]                          mode,
    output logic [B_LEN-1:0][SYM_WIDTH-1:0]     final_symbols,
    output logic                                delayed_run,
    output logic                                delayed_initialize,
    output logic                                delayed_frame_end,
    output logic [$clog2(num_of_channels)-1:0]  delayed_frame_position,
    output logic                                seq_error,
    output logic [15:0]                         frame_count
);

    localparam int POS_W = $clog2(num_of_channels);
    localparam int CTL_W = POS_W + 3;
    localparam logic [SYM_WIDTH-1:0] SYM_POS = SYM_WIDTH'(1);
    localparam logic [SYM_WIDTH-1:0] SYM_NEG = '1;
    localparam logic [POS_W-1:0]     POS_MAX = POS_W'(num_of_channels - 1);

    mode_t                          mode_q;
    logic                           count_mode;
    logic [B_LEN-1:0][SYM_WIDTH-1:0] cnt_q;
    logic [B_LEN-1:0][SYM_WIDTH-1:0] sym_s0;
    logic [6:0]                     lfsr_q;
    logic [6:0]                     lfsr_walk;
    logic [B_LEN-1:0]               prbs_bits;
    logic [POS_W-1:0]               last_pos_q;
    logic [POS_W-1:0]               next_pos;
    logic                           have_last_q;
    logic [CTL_W-1:0]               ctl_q;
    logic                           unused_rse;

    // only the sign bit of each residual value matters
    assign unused_rse = ^rse_vals;

    assign count_mode = (mode_q == MODE_COUNT) || (mode_q == MODE_RSVD);

    always_ff @(posedge clk) begin
        if (rst)
            mode_q <= MODE_COUNT;
        else if (initialize)
            mode_q <= mode_t'(mode);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (initialize) begin
            for (int jj = 0; jj < B_LEN; jj++)
                cnt_q[jj] <= SYM_POS;
        end else if (run && count_mode) begin
            for (int jj = 0; jj < B_LEN; jj++)
                cnt_q[jj] <= cnt_q[jj] + SYM_POS;
        end
    end

    // lane jj takes the jj-th of the B_LEN bits produced this cycle
    always_comb begin
        lfsr_walk = lfsr_q;
        prbs_bits = '0;
        for (int jj = 0; jj < B_LEN; jj++) begin
            lfsr_walk     = lfsr_step(lfsr_walk);
            prbs_bits[jj] = lfsr_walk[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || initialize)
            lfsr_q <= LFSR_SEED;
        else if (run && mode_q == MODE_PRBS)
            lfsr_q <= lfsr_walk;
    end

    always_comb begin
        sym_s0 = '0;
        if (run && !initialize) begin
            for (int jj = 0; jj < B_LEN; jj++) begin
                case (mode_q)
                    MODE_SLICE: sym_s0[jj] = rse_vals[jj][B_WIDTH-1] ? SYM_NEG : SYM_POS;
                    MODE_PRBS:  sym_s0[jj] = prbs_bits[jj] ? SYM_POS : SYM_NEG;
                    default:    sym_s0[jj] = cnt_q[jj];
                endcase
            end
        end
    end

    assign next_pos = (last_pos_q == POS_MAX) ? '0 : last_pos_q + POS_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_error   <= 1'b0;
            have_last_q <= 1'b0;
            last_pos_q  <= '0;
        end else if (initialize) begin
            seq_error   <= 1'b0;
            have_last_q <= 1'b0;
        end else if (run) begin
            if (have_last_q && frame_position != next_pos)
                seq_error <= 1'b1;
            last_pos_q  <= frame_position;
            have_last_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || initialize)
            frame_count <= '0;
        else if (delayed_frame_end && delayed_run && frame_count != 16'hFFFF)
            frame_count <= frame_count + 16'd1;
    end

    viterbi_delay_line #(
        .WIDTH (CTL_W),
        .DEPTH (H_DEPTH)
    ) u_ctl_dly (
        .clk   (clk),
        .clr   (rst),
        .flush (1'b0),
        .d     ({run, initialize, frame_end, frame_position}),
        .q     (ctl_q)
    );

    assign {delayed_run, delayed_initialize, delayed_frame_end, delayed_frame_position} = ctl_q;

    // initialize drops in-flight symbols but lets control keep flowing
    viterbi_delay_line #(
        .WIDTH (B_LEN * SYM_WIDTH),
        .DEPTH (H_DEPTH)
    ) u_sym_dly (
        .clk   (clk),
        .clr   (rst),
        .flush (initialize),
        .d     (sym_s0),
        .q     (final_symbols)
    );

endmodule

// File: tb/tb_flex_viterbi_core.sv
// Bench for flex_viterbi_core: directed table, corner sequences, and random
// traffic against a cycle-history reference model.
module tb_flex_viterbi_core;

    localparam int N    = 40;
    localparam int BW   = 8;
    localparam int BL   = 2;
    localparam int SW   = 3;
    localparam int H    = 6;
    localparam int PW   = $clog2(N);
    localparam int MAXS = 2048;

    logic                  clk;
    logic                  rst;
    logic [BL-1:0][BW-1:0] rse_vals;
    logic                  run, initialize, frame_end;
    logic [PW-1:0]         frame_position;
    logic [1:0]            mode;
    logic [BL-1:0][SW-1:0] final_symbols;
    logic                  delayed_run, delayed_initialize, delayed_frame_end;
    logic [PW-1:0]         delayed_frame_position;
    logic                  seq_error;
    logic [15:0]           frame_count;

    flex_viterbi_core #(
        .num_of_channels (N),
        .B_WIDTH         (BW),
        .B_LEN           (BL),
        .SYM_WIDTH       (SW),
        .H_DEPTH         (H)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .rse_vals               (rse_vals),
        .run                    (run),
        .initialize             (initialize),
        .frame_end              (frame_end),
        .frame_position         (frame_position),
        .mode                   (mode),
        .final_symbols          (final_symbols),
        .delayed_run            (delayed_run),
        .delayed_initialize     (delayed_initialize),
        .delayed_frame_end      (delayed_frame_end),
        .delayed_frame_position (delayed_frame_position),
        .seq_error              (seq_error),
        .frame_count            (frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // reference model: per-cycle history of stage-0 values plus frame state
    int n = 0;
    int h_run [MAXS];
    int h_init[MAXS];
    int h_fe  [MAXS];
    int h_pos [MAXS];
    int h_sym [MAXS][BL];
    int m_mode, m_cnt, m_have, m_last, m_seq, m_fc;
    bit lq[$];

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d: got %0d, expected %0d", name, n, act, exp);
        end
    endtask

    task automatic reseed();
        lq.delete();
        repeat (7) lq.push_back(1'b1);
    endtask

    task automatic clear_hist(input int k);
        h_run[k] = 0; h_init[k] = 0; h_fe[k] = 0; h_pos[k] = 0;
        for (int l = 0; l < BL; l++) h_sym[k][l] = 0;
    endtask

    task automatic step(input bit r, input bit i, input bit ru, input bit fe,
                        input int md, input int pos, input int rv0, input int rv1);
        int s [BL];
        int rv[BL];
        int idx, v;
        bit nb;
        if (n >= MAXS) begin
            $display("FAIL hist_overflow: step %0d, limit %0d", n, MAXS);
            $fatal(1);
        end
        rst = r; initialize = i; run = ru; frame_end = fe;
        mode = 2'(md);
        frame_position = PW'(pos);
        rse_vals[0] = BW'(rv0);
        rse_vals[1] = BW'(rv1);
        @(posedge clk);
        #1;
        rv[0] = rv0; rv[1] = rv1;
        for (int l = 0; l < BL; l++) s[l] = 0;
        if (r) begin
            m_mode = 0; m_cnt = 0; m_have = 0; m_last = 0; m_seq = 0; m_fc = 0;
            reseed();
            for (int k = (n > H ? n - H : 0); k <= n; k++) clear_hist(k);
        end else begin
            if (i) m_fc = 0;
            else if (n >= H && h_run[n-H] != 0 && h_fe[n-H] != 0 && m_fc < 65535) m_fc++;
            if (i) begin
                m_seq = 0; m_have = 0;
            end else if (ru) begin
                if (m_have != 0 && pos != (m_last + 1) % N) m_seq = 1;
                m_last = pos; m_have = 1;
            end
            if (i) begin
                m_mode = md; m_cnt = 1;
                reseed();
            end else if (ru) begin
                if (m_mode == 1) begin
                    for (int l = 0; l < BL; l++) s[l] = (rv[l] >= 0) ? 1 : -1;
                end else if (m_mode == 2) begin
                    for (int l = 0; l < BL; l++) begin
                        nb = lq[lq.size()-7] ^ lq[lq.size()-6];
                        lq.push_back(nb);
                        void'(lq.pop_front());
                        s[l] = nb ? 1 : -1;
                    end
                end else begin
                    v = m_cnt % (1 << SW);
                    if (v >= (1 << (SW - 1))) v -= (1 << SW);
                    for (int l = 0; l < BL; l++) s[l] = v;
                    m_cnt = (m_cnt + 1) % (1 << SW);
                end
            end
            h_run[n] = ru; h_init[n] = i; h_fe[n] = fe; h_pos[n] = pos;
            for (int l = 0; l < BL; l++) h_sym[n][l] = s[l];
            if (i)
                for (int j = 1; j <= H - 2; j++)
                    if (n - j >= 0)
                        for (int l = 0; l < BL; l++) h_sym[n-j][l] = 0;
        end
        idx = n - H + 1;
        for (int l = 0; l < BL; l++)
            chk($sformatf("m_sym%0d", l), $signed(final_symbols[l]), idx >= 0 ? h_sym[idx][l] : 0);
        chk("m_drun",  {31'd0, delayed_run},        idx >= 0 ? h_run[idx]  : 0);
        chk("m_dinit", {31'd0, delayed_initialize}, idx >= 0 ? h_init[idx] : 0);
        chk("m_dfe",   {31'd0, delayed_frame_end},  idx >= 0 ? h_fe[idx]   : 0);
        chk("m_dpos",  {26'd0, delayed_frame_position}, idx >= 0 ? h_pos[idx] : 0);
        chk("m_seq",   {31'd0, seq_error},   m_seq);
        chk("m_fcnt",  {16'd0, frame_count}, m_fc);
        n++;
    endtask

    typedef struct {
        bit init;
        bit run;
        int mode;
        int pos;
        int r0;
        int r1;
        int e0;
        int e1;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int rpos, rr0, rr1;
        bit ri, rru, rfe, rr;

        // directed table: COUNT 1,2,3,-4 then SLICE {-5,0} -> {-1,+1}
        tbl[0]  = '{1'b1, 1'b0, 0, 0,  0, 0,  0, 0};
        tbl[1]  = '{1'b0, 1'b1, 0, 0,  0, 0,  0, 0};
        tbl[2]  = '{1'b0, 1'b1, 0, 1,  0, 0,  0, 0};
        tbl[3]  = '{1'b0, 1'b1, 0, 2,  0, 0,  0, 0};
        tbl[4]  = '{1'b0, 1'b1, 0, 3,  0, 0,  0, 0};
        tbl[5]  = '{1'b0, 1'b0, 0, 0,  0, 0,  0, 0};
        tbl[6]  = '{1'b0, 1'b0, 0, 0,  0, 0,  1, 1};
        tbl[7]  = '{1'b0, 1'b0, 0, 0,  0, 0,  2, 2};
        tbl[8]  = '{1'b0, 1'b0, 0, 0,  0, 0,  3, 3};
        tbl[9]  = '{1'b0, 1'b0, 0, 0,  0, 0, -4, -4};
        tbl[10] = '{1'b0, 1'b0, 0, 0,  0, 0,  0, 0};
        tbl[11] = '{1'b1, 1'b0, 1, 0,  0, 0,  0, 0};
        tbl[12] = '{1'b0, 1'b1, 0, 0, -5, 0,  0, 0};
        tbl[13] = '{1'b0, 1'b0, 0, 0,  0, 0,  0, 0};
        tbl[14] = '{1'b0, 1'b0, 0, 0,  0, 0,  0, 0};
        tbl[15] = '{1'b0, 1'b0, 0, 0,  0, 0,  0, 0};
        tbl[16] = '{1'b0, 1'b0, 0, 0,  0, 0,  0, 0};
        tbl[17] = '{1'b0, 1'b0, 0, 0,  0, 0, -1, 1};
        tbl[18] = '{1'b0, 1'b0, 0, 0,  0, 0,  0, 0};

        reseed();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 5, 0, 0);
        chk("rst_sym0", $signed(final_symbols[0]), 0);
        chk("rst_drun", {31'd0, delayed_run}, 0);
        chk("rst_seq",  {31'd0, seq_error}, 0);
        chk("rst_fcnt", {16'd0, frame_count}, 0);

        for (int k = 0; k < 19; k++) begin
            step(0, tbl[k].init, tbl[k].run, 0, tbl[k].mode, tbl[k].pos, tbl[k].r0, tbl[k].r1);
            chk($sformatf("tbl%0d_sym0", k), $signed(final_symbols[0]), tbl[k].e0);
            chk($sformatf("tbl%0d_sym1", k), $signed(final_symbols[1]), tbl[k].e1);
        end

        // PRBS stream from seed, checked by the bit-recurrence model
        step(0, 1, 0, 0, 2, 0, 0, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 1, 0, 0, k, 0, 0);
        for (int k = 0; k < H; k++) step(0, 0, 0, 0, 0, 0, 0, 0);

        // position wrap is legal; a skip latches seq_error until initialize
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 38, 0, 0); chk("seq_38", {31'd0, seq_error}, 0);
        step(0, 0, 1, 0, 0, 39, 0, 0); chk("seq_39", {31'd0, seq_error}, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);  chk("seq_0",  {31'd0, seq_error}, 0);
        step(0, 0, 1, 0, 0, 1, 0, 0);  chk("seq_1",  {31'd0, seq_error}, 0);
        step(0, 0, 1, 0, 0, 3, 0, 0);  chk("seq_3",  {31'd0, seq_error}, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);  chk("seq_hold", {31'd0, seq_error}, 1);
        step(0, 0, 1, 0, 0, 4, 0, 0);  chk("seq_sticky", {31'd0, seq_error}, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);  chk("seq_clr", {31'd0, seq_error}, 0);

        // 40 completed frames, then reset in the middle of traffic
        for (int k = 0; k < H; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 40; k++) step(0, 0, 1, 1, 0, k, 0, 0);
        for (int k = 0; k <= H; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("fcnt_40", {16'd0, frame_count}, 40);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 0, k, 0, 0);
        step(1, 0, 1, 1, 0, 3, 0, 0);
        chk("midrst_sym0",  $signed(final_symbols[0]), 0);
        chk("midrst_sym1",  $signed(final_symbols[1]), 0);
        chk("midrst_drun",  {31'd0, delayed_run}, 0);
        chk("midrst_dinit", {31'd0, delayed_initialize}, 0);
        chk("midrst_dfe",   {31'd0, delayed_frame_end}, 0);
        chk("midrst_dpos",  {26'd0, delayed_frame_position}, 0);
        chk("midrst_seq",   {31'd0, seq_error}, 0);
        chk("midrst_fcnt",  {16'd0, frame_count}, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);

        // random traffic; positions stay in range and mostly sequential
        rpos = 0;
        step(0, 1, 0, 0, int'($urandom_range(0, 3)), 0, 0, 0);
        for (int k = 0; k < 700; k++) begin
            rr  = ($urandom_range(0, 99) == 0);
            ri  = ($urandom_range(0, 15) == 0);
            rru = ($urandom_range(0, 3) != 0);
            rfe = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) rpos = int'($urandom_range(0, N - 1));
            else if (rru) rpos = (rpos + 1) % N;
            rr0 = int'($urandom_range(0, 255)) - 128;
            rr1 = int'($urandom_range(0, 255)) - 128;
            step(rr, ri, rru, rfe, int'($urandom_range(0, 3)), rpos, rr0, rr1);
        end
        for (int k = 0; k < H; k++) step(0, 0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
